// File: rtl/id_ex_register_pkg.sv
// Shared ID/EX definitions: control-word layout, bubble word and field helpers
// used by decode (packing) and execute (extraction).
package id_ex_register_pkg;

    localparam int NB_REGS      = 5;
    localparam int NB_SIZE_TYPE = 3;
    localparam int NB_EXT       = 2;
    localparam int NB_CTRL      = 19;

    localparam int CTRL_ALU_SRC     = 18;
    localparam int CTRL_MEM_READ    = 17;
    localparam int CTRL_MEM_WRITE   = 16;
    localparam int CTRL_MEM_TO_REG  = 15;
    localparam int CTRL_REG_WRITE   = 14;
    localparam int CTRL_REG_DIR_MSB = 13;
    localparam int CTRL_REG_DIR_LSB = 9;
    localparam int CTRL_BRANCH      = 8;
    localparam int CTRL_JUMP        = 7;
    localparam int CTRL_JR_JALR     = 6;
    localparam int CTRL_SIGNED      = 5;
    localparam int CTRL_EXT_MSB     = 4;
    localparam int CTRL_EXT_LSB     = 3;
    localparam int CTRL_WS_MSB      = 2;
    localparam int CTRL_WS_LSB      = 0;

    typedef enum logic [NB_EXT-1:0] {
        EXT_SIGNED   = 2'b00,
        EXT_UNSIGNED = 2'b01,
        EXT_UPPER    = 2'b10
    } ext_mode_e;

    typedef enum logic [NB_SIZE_TYPE-1:0] {
        WS_BYTE = 3'b001,
        WS_HALF = 3'b010,
        WS_WORD = 3'b100
    } word_size_e;

    // No enables set, signed extension, full-word access
    localparam logic [NB_CTRL-1:0] CTRL_BUBBLE = {14'd0, 2'b00, 3'b100};

    function automatic logic [NB_CTRL-1:0] ctrl_pack(
        input logic               alu_src,
        input logic               mem_read,
        input logic               mem_write,
        input logic               mem_to_reg,
        input logic               reg_write,
        input logic [NB_REGS-1:0] reg_dir,
        input logic               branch,
        input logic               jump,
        input logic               jr_jalr,
        input logic               sgn,
        input ext_mode_e          ext_mode,
        input word_size_e         word_size
    );
        return {alu_src, mem_read, mem_write, mem_to_reg, reg_write, reg_dir,
                branch, jump, jr_jalr, sgn, ext_mode, word_size};
    endfunction

    function automatic logic ctrl_mem_read(input logic [NB_CTRL-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

    function automatic logic ctrl_reg_write(input logic [NB_CTRL-1:0] ctrl);
        return ctrl[CTRL_REG_WRITE];
    endfunction

    function automatic logic [NB_REGS-1:0] ctrl_reg_dir(input logic [NB_CTRL-1:0] ctrl);
        return ctrl[CTRL_REG_DIR_MSB:CTRL_REG_DIR_LSB];
    endfunction

    function automatic logic [NB_SIZE_TYPE-1:0] ctrl_word_size(input logic [NB_CTRL-1:0] ctrl);
        return ctrl[CTRL_WS_MSB:CTRL_WS_LSB];
    endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// Decode-to-execute bundle: pipeline controls, decode payload in, registered payload
// and load-use stall request out.
interface id_ex_register_if
    import id_ex_register_pkg::*;
#(
    parameter int NB = 32
);
    logic               i_step;
    logic               i_stall;
    logic               i_flush;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB-1:0]      i_instruction;
    logic [NB-1:0]      i_rs_data;
    logic [NB-1:0]      i_rt_data;
    logic [NB-1:0]      i_immediate;
    logic [NB-1:0]      i_pc4;

    logic [NB_CTRL-1:0] o_ctrl;
    logic [NB-1:0]      o_instruction;
    logic [NB-1:0]      o_rs_data;
    logic [NB-1:0]      o_rt_data;
    logic [NB-1:0]      o_immediate;
    logic [NB-1:0]      o_pc4;
    logic               o_valid;
    logic               o_load_use_hazard;

    modport master (
        output i_step, i_stall, i_flush, i_ctrl, i_instruction,
               i_rs_data, i_rt_data, i_immediate, i_pc4,
        input  o_ctrl, o_instruction, o_rs_data, o_rt_data,
               o_immediate, o_pc4, o_valid, o_load_use_hazard
    );

    modport slave (
        input  i_step, i_stall, i_flush, i_ctrl, i_instruction,
               i_rs_data, i_rt_data, i_immediate, i_pc4,
        output o_ctrl, o_instruction, o_rs_data, o_rt_data,
               o_immediate, o_pc4, o_valid, o_load_use_hazard
    );
endinterface

// File: rtl/id_ex_register_load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in decode.
// Destination $0 is never a hazard.
module id_ex_register_load_use_detector
    import id_ex_register_pkg::*;
(
    input  logic               o_valid,
    input  logic               mem_read,
    input  logic [NB_REGS-1:0] reg_dir,
    input  logic [NB_REGS-1:0] rs,
    input  logic [NB_REGS-1:0] rt,
    output logic               hazard
);

    logic dir_nonzero_s;
    logic dir_match_s;

    assign dir_nonzero_s = (reg_dir != {NB_REGS{1'b0}});
    // rt is compared even for I-types; the occasional spurious stall is harmless
    assign dir_match_s   = (reg_dir == rs) | (reg_dir == rt);
    assign hazard        = o_valid & mem_read & dir_nonzero_s & dir_match_s;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: holds on step/stall, bubbles on flush or load-use,
// otherwise captures the decode payload.
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int NB = 32
)(
    input logic               i_clk,
    input logic               i_reset,
    id_ex_register_if.slave   bus
);

    logic [NB_CTRL-1:0] ctrl_r,  ctrl_s;
    logic [NB-1:0]      instr_r, instr_s;
    logic [NB-1:0]      rs_r,    rs_s;
    logic [NB-1:0]      rt_r,    rt_s;
    logic [NB-1:0]      imm_r,   imm_s;
    logic [NB-1:0]      pc4_r,   pc4_s;
    logic               valid_r, valid_s;
    logic               hazard_s;

    id_ex_register_load_use_detector u_load_use_detector (
        .o_valid  (valid_r),
        .mem_read (ctrl_mem_read(ctrl_r)),
        .reg_dir  (ctrl_reg_dir(ctrl_r)),
        .rs       (bus.i_instruction[25:21]),
        .rt       (bus.i_instruction[20:16]),
        .hazard   (hazard_s)
    );

    // Next-slot selection: hold beats bubble beats load
    always_comb begin
        ctrl_s  = ctrl_r;
        instr_s = instr_r;
        rs_s    = rs_r;
        rt_s    = rt_r;
        imm_s   = imm_r;
        pc4_s   = pc4_r;
        valid_s = valid_r;
        if (!bus.i_step || bus.i_stall) begin
            ctrl_s  = ctrl_r;
            valid_s = valid_r;
        end else if (bus.i_flush || hazard_s) begin
            ctrl_s  = CTRL_BUBBLE;
            instr_s = {NB{1'b0}};
            rs_s    = {NB{1'b0}};
            rt_s    = {NB{1'b0}};
            imm_s   = {NB{1'b0}};
            pc4_s   = {NB{1'b0}};
            valid_s = 1'b0;
        end else begin
            ctrl_s  = bus.i_ctrl;
            instr_s = bus.i_instruction;
            rs_s    = bus.i_rs_data;
            rt_s    = bus.i_rt_data;
            imm_s   = bus.i_immediate;
            pc4_s   = bus.i_pc4;
            valid_s = 1'b1;
        end
    end

    // Slot state; reset leaves an empty bubble with no residual hazard
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ctrl_r  <= CTRL_BUBBLE;
            instr_r <= {NB{1'b0}};
            rs_r    <= {NB{1'b0}};
            rt_r    <= {NB{1'b0}};
            imm_r   <= {NB{1'b0}};
            pc4_r   <= {NB{1'b0}};
            valid_r <= 1'b0;
        end else begin
            ctrl_r  <= ctrl_s;
            instr_r <= instr_s;
            rs_r    <= rs_s;
            rt_r    <= rt_s;
            imm_r   <= imm_s;
            pc4_r   <= pc4_s;
            valid_r <= valid_s;
        end
    end

    assign bus.o_ctrl            = ctrl_r;
    assign bus.o_instruction     = instr_r;
    assign bus.o_rs_data         = rs_r;
    assign bus.o_rt_data         = rt_r;
    assign bus.o_immediate       = imm_r;
    assign bus.o_pc4             = pc4_r;
    assign bus.o_valid           = valid_r;
    assign bus.o_load_use_hazard = hazard_s;

endmodule
